// File: rtl/ip_codma_pkg.sv
// Shared types and constants for the CODMA front end: scheduler state
// encoding, the start-to-busy grace period and a round-robin helper.
package ip_codma_pkg;

  typedef enum logic [2:0] {
    SCH_IDLE,
    SCH_LAUNCH,
    SCH_WAIT_BUSY,
    SCH_RUN,
    SCH_DRAIN
  } sched_state_t;

  // Cycles the engine may take to raise busy after a start pulse.
  localparam int SCHED_BUSY_WAIT = 4;

  // Next round-robin pointer after a grant, wrapping at the channel count.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned numCh);
    return (cur + 1 >= numCh) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/ip_codma_task_scheduler_if.sv
// Bundles the channel-side request/ack signals and the engine-side
// start/stop/pointer signals of the task scheduler. The slave modport is
// the scheduler's own view; master is the requesters plus engine.
interface ip_codma_task_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        ch_req_i;
  logic [NUM_CH-1:0][31:0]  ch_task_ptr_i;
  logic [NUM_CH-1:0][31:0]  ch_status_ptr_i;
  logic [NUM_CH-1:0]        ch_abort_i;
  logic [NUM_CH-1:0]        ch_ack_o;
  logic [NUM_CH-1:0]        ch_done_o;
  logic [NUM_CH-1:0]        ch_err_o;
  logic [TMO_W-1:0]         timeout_i;
  logic                     dma_start_o;
  logic                     dma_stop_o;
  logic [31:0]              dma_task_ptr_o;
  logic [31:0]              dma_status_ptr_o;
  logic                     dma_busy_i;
  logic                     dma_irq_i;
  logic                     dma_err_i;
  logic [CH_W-1:0]          active_ch_o;
  logic                     sched_busy_o;

  modport slave (
    input  ch_req_i, ch_task_ptr_i, ch_status_ptr_i, ch_abort_i, timeout_i,
    input  dma_busy_i, dma_irq_i, dma_err_i,
    output ch_ack_o, ch_done_o, ch_err_o,
    output dma_start_o, dma_stop_o, dma_task_ptr_o, dma_status_ptr_o,
    output active_ch_o, sched_busy_o
  );

  modport master (
    output ch_req_i, ch_task_ptr_i, ch_status_ptr_i, ch_abort_i, timeout_i,
    output dma_busy_i, dma_irq_i, dma_err_i,
    input  ch_ack_o, ch_done_o, ch_err_o,
    input  dma_start_o, dma_stop_o, dma_task_ptr_o, dma_status_ptr_o,
    input  active_ch_o, sched_busy_o
  );

endinterface

// File: rtl/ip_codma_rr_arbiter.sv
// Combinational rotating-priority pick: returns the first requesting
// channel at or after rr_ptr_i, wrapping modulo NUM_CH.
module ip_codma_rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  rr_ptr_i,
  output logic [IDX_W-1:0]  grant_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(rr_ptr_i) + i) % NUM_CH);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_codma_task_scheduler.sv
// Multi-channel front end for the CODMA engine: round-robin grant,
// one task in flight, busy-response and run watchdogs, abort via stop,
// and exactly one done or err pulse per granted task.
module ip_codma_task_scheduler
  import ip_codma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  ip_codma_task_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CH);

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]  activeCh_q, activeCh_d;
  logic [TMO_W-1:0]  wdCnt_q, wdCnt_d;
  logic [31:0]       taskPtr_q, taskPtr_d;
  logic [31:0]       statusPtr_q, statusPtr_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              sbusy_q, sbusy_d;

  logic [IDX_W-1:0]  grantIdx;
  logic              grantValid;

  ip_codma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i    (bus.ch_req_i),
    .rr_ptr_i (rrPtr_q),
    .grant_o  (grantIdx),
    .valid_o  (grantValid)
  );

  // Next-state and registered-output decode for the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    activeCh_d  = activeCh_q;
    wdCnt_d     = wdCnt_q;
    taskPtr_d   = taskPtr_q;
    statusPtr_d = statusPtr_q;
    ack_d       = '0;
    done_d      = '0;
    err_d       = '0;
    start_d     = 1'b0;
    stop_d      = 1'b0;

    case (state_q)
      SCH_IDLE: begin
        wdCnt_d = '0;
        if (grantValid && !bus.dma_busy_i) begin
          activeCh_d      = grantIdx;
          taskPtr_d       = bus.ch_task_ptr_i[grantIdx];
          statusPtr_d     = bus.ch_status_ptr_i[grantIdx];
          ack_d[grantIdx] = 1'b1;
          start_d         = 1'b1;
          state_d         = SCH_LAUNCH;
        end
      end

      SCH_LAUNCH: begin
        rrPtr_d = IDX_W'(rr_next(32'(activeCh_q), NUM_CH));
        wdCnt_d = '0;
        state_d = SCH_WAIT_BUSY;
      end

      SCH_WAIT_BUSY: begin
        if (bus.dma_busy_i) begin
          wdCnt_d = '0;
          state_d = SCH_RUN;
        end else if (wdCnt_q == TMO_W'(SCHED_BUSY_WAIT - 1)) begin
          err_d[activeCh_q] = 1'b1;
          wdCnt_d           = '0;
          state_d           = SCH_IDLE;
        end else begin
          wdCnt_d = wdCnt_q + TMO_W'(1);
        end
      end

      SCH_RUN: begin
        if (bus.dma_err_i) begin
          err_d[activeCh_q] = 1'b1;
          wdCnt_d           = '0;
          state_d           = SCH_DRAIN;
        end else if (bus.dma_irq_i) begin
          done_d[activeCh_q] = 1'b1;
          wdCnt_d            = '0;
          state_d            = SCH_IDLE;
        end else if (bus.ch_abort_i[activeCh_q] ||
                     ((bus.timeout_i != '0) && (wdCnt_q == bus.timeout_i - TMO_W'(1)))) begin
          stop_d            = 1'b1;
          err_d[activeCh_q] = 1'b1;
          wdCnt_d           = '0;
          state_d           = SCH_DRAIN;
        end else begin
          wdCnt_d = wdCnt_q + TMO_W'(1);
        end
      end

      SCH_DRAIN: begin
        if (!bus.dma_busy_i) begin
          state_d = SCH_IDLE;
        end
      end

      default: begin
        state_d = SCH_IDLE;
      end
    endcase

    sbusy_d = (state_d != SCH_IDLE);
  end

  // State, pointer, watchdog and output registers; reset drops any task in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= SCH_IDLE;
      rrPtr_q     <= '0;
      activeCh_q  <= '0;
      wdCnt_q     <= '0;
      taskPtr_q   <= '0;
      statusPtr_q <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      sbusy_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      activeCh_q  <= activeCh_d;
      wdCnt_q     <= wdCnt_d;
      taskPtr_q   <= taskPtr_d;
      statusPtr_q <= statusPtr_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      sbusy_q     <= sbusy_d;
    end
  end

  assign bus.ch_ack_o         = ack_q;
  assign bus.ch_done_o        = done_q;
  assign bus.ch_err_o         = err_q;
  assign bus.dma_start_o      = start_q;
  assign bus.dma_stop_o       = stop_q;
  assign bus.dma_task_ptr_o   = taskPtr_q;
  assign bus.dma_status_ptr_o = statusPtr_q;
  assign bus.active_ch_o      = activeCh_q;
  assign bus.sched_busy_o     = sbusy_q;

endmodule

// File: tb/tb_ip_codma_task_scheduler.sv
// Directed bench for the CODMA task scheduler: a per-cycle vector table
// for arbitration order and event collisions, plus hand-written sequences
// for the long-running watchdog, abort, no-busy and mid-task reset cases.
module tb_ip_codma_task_scheduler;

  localparam int NUM_CH = 4;
  localparam int TMO_W  = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ip_codma_task_scheduler_if #(.NUM_CH(NUM_CH), .TMO_W(TMO_W)) bus ();

  ip_codma_task_scheduler #(.NUM_CH(NUM_CH), .TMO_W(TMO_W)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] abort;
    logic       busy;
    logic       irq;
    logic       err;
    logic [3:0] ack;
    logic [3:0] done;
    logic [3:0] errP;
    logic       start;
    logic       stop;
    logic       sbusy;
    int         ch;
  } vec_t;

  vec_t        vecs [27];
  logic [31:0] taskTbl [4];
  logic [31:0] statusTbl [4];
  int          vecCount  = 0;
  int          missCount = 0;
  logic [8:0]  acc;
  int          cycles;
  logic        stopSeen;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [8:0] pulses();
    return {bus.dma_stop_o, bus.ch_done_o, bus.ch_err_o};
  endfunction

  function automatic logic [80:0] allOut();
    return {bus.ch_ack_o, bus.ch_done_o, bus.ch_err_o, bus.dma_start_o, bus.dma_stop_o,
            bus.sched_busy_o, bus.active_ch_o, bus.dma_task_ptr_o, bus.dma_status_ptr_o};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
    vecCount++;
    if (act !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, act, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bus.ch_req_i   = v.req;
    bus.ch_abort_i = v.abort;
    bus.dma_busy_i = v.busy;
    bus.dma_irq_i  = v.irq;
    bus.dma_err_i  = v.err;
    step();
    checkOutput($sformatf("vec%0d", idx),
      128'({bus.ch_ack_o, bus.ch_done_o, bus.ch_err_o, bus.dma_start_o, bus.dma_stop_o,
            bus.sched_busy_o, (v.sbusy ? bus.active_ch_o : 2'b00),
            bus.dma_task_ptr_o, bus.dma_status_ptr_o}),
      128'({v.ack, v.done, v.errP, v.start, v.stop, v.sbusy, (v.sbusy ? 2'(v.ch) : 2'b00),
            taskTbl[v.ch], statusTbl[v.ch]}));
  endtask

  task automatic idleInputs();
    bus.ch_req_i   = '0;
    bus.ch_abort_i = '0;
    bus.dma_busy_i = 1'b0;
    bus.dma_irq_i  = 1'b0;
    bus.dma_err_i  = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    step();
    checkOutput("reset_state", 128'(allOut()), 128'(0));
    rst_n = 1'b1;
    step();
  endtask

  // Request one channel, check the grant, then let the engine go busy.
  // Returns at the first RUN cycle with busy still driven high.
  task automatic launchTask(input int ch);
    bus.ch_req_i = 4'(1 << ch);
    step();
    checkOutput($sformatf("launch%0d_ack", ch),
      128'({bus.ch_ack_o, bus.dma_start_o, bus.active_ch_o}),
      128'({4'(1 << ch), 1'b1, 2'(ch)}));
    bus.ch_req_i = '0;
    step();
    bus.dma_busy_i = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    taskTbl   = '{32'h0000_0040, 32'h0000_0100, 32'h0000_0180, 32'h0000_01C0};
    statusTbl = '{32'h0000_0140, 32'h0000_0200, 32'h0000_0280, 32'h0000_02C0};
    for (int k = 0; k < NUM_CH; k++) begin
      bus.ch_task_ptr_i[k]   = taskTbl[k];
      bus.ch_status_ptr_i[k] = statusTbl[k];
    end
    idleInputs();
    bus.timeout_i = '0;

    //           req      abort    bsy   irq   err   ack      done     err      start stop  sbusy ch
    vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 0};
    vecs[1]  = '{4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 0};
    vecs[2]  = '{4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 0};
    vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1};
    vecs[5]  = '{4'b1101, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{4'b1101, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{4'b1101, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'b1101, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2};
    vecs[9]  = '{4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2};
    vecs[10] = '{4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2};
    vecs[11] = '{4'b1001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2};
    vecs[12] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 3};
    vecs[13] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 3};
    vecs[14] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 3};
    vecs[15] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 3};
    vecs[16] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 0};
    vecs[17] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 0};
    vecs[18] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 0};
    vecs[19] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 0};
    vecs[20] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 0};
    vecs[21] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
    vecs[22] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2};
    vecs[23] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2};
    vecs[24] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2};
    vecs[25] = '{4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2};
    vecs[26] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2};

    $display("[TB] reset");
    doReset();

    $display("[TB] single channel task on ch1");
    bus.ch_req_i = 4'b0010;
    step();
    checkOutput("single_ack", 128'({bus.ch_ack_o, bus.dma_start_o, bus.active_ch_o}),
                128'({4'b0010, 1'b1, 2'd1}));
    checkOutput("single_ptrs", 128'({bus.dma_task_ptr_o, bus.dma_status_ptr_o}),
                128'({32'h0000_0100, 32'h0000_0200}));
    bus.ch_req_i = '0;
    step();
    bus.dma_busy_i = 1'b1;
    step();
    acc = pulses();
    for (int c = 0; c < 19; c++) begin
      step();
      acc |= pulses();
    end
    checkOutput("single_quiet", 128'(acc), 128'(0));
    bus.dma_irq_i = 1'b1;
    step();
    checkOutput("single_done", 128'({bus.ch_done_o, bus.ch_err_o}), 128'({4'b0010, 4'b0000}));
    bus.dma_irq_i  = 1'b0;
    bus.dma_busy_i = 1'b0;
    step();
    checkOutput("single_once", 128'({pulses(), bus.sched_busy_o}), 128'(0));

    $display("[TB] round-robin and collision table");
    doReset();
    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i], i);
    end
    idleInputs();

    $display("[TB] watchdog");
    bus.timeout_i = 16'd50;
    launchTask(3);
    cycles   = 0;
    stopSeen = 1'b0;
    acc      = pulses();
    while (!stopSeen && cycles < 60) begin
      step();
      cycles++;
      if (bus.dma_stop_o) stopSeen = 1'b1;
      else acc |= pulses();
    end
    checkOutput("wdog_delay", 128'(cycles), 128'(50));
    checkOutput("wdog_stop_err", 128'({bus.dma_stop_o, bus.ch_err_o, bus.ch_done_o, acc}),
                128'({1'b1, 4'b1000, 4'b0000, 9'd0}));
    bus.dma_irq_i = 1'b1;
    step();
    bus.dma_irq_i = 1'b0;
    acc = pulses();
    step();
    acc |= pulses();
    checkOutput("drain_swallow", 128'({acc, bus.sched_busy_o}), 128'({9'd0, 1'b1}));
    bus.dma_busy_i = 1'b0;
    step();
    checkOutput("drain_exit", 128'({pulses(), bus.sched_busy_o}), 128'(0));
    bus.timeout_i = '0;

    $display("[TB] abort");
    launchTask(2);
    acc = pulses();
    bus.ch_abort_i = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      step();
      acc |= pulses();
    end
    bus.ch_abort_i = 4'b0100;
    step();
    checkOutput("abort_other_ignored", 128'(acc), 128'(0));
    checkOutput("abort_stop_err", 128'({bus.dma_stop_o, bus.ch_err_o, bus.ch_done_o}),
                128'({1'b1, 4'b0100, 4'b0000}));
    bus.ch_abort_i = '0;
    bus.dma_busy_i = 1'b0;
    step();
    checkOutput("abort_exit", 128'({pulses(), bus.sched_busy_o}), 128'(0));

    $display("[TB] engine ignores start");
    bus.ch_req_i = 4'b0001;
    step();
    checkOutput("nobusy_ack", 128'({bus.ch_ack_o, bus.dma_start_o}), 128'({4'b0001, 1'b1}));
    bus.ch_req_i = '0;
    step();
    acc = pulses();
    for (int c = 0; c < 3; c++) begin
      step();
      acc |= pulses();
    end
    checkOutput("nobusy_early", 128'({acc, bus.sched_busy_o}), 128'({9'd0, 1'b1}));
    step();
    checkOutput("nobusy_err", 128'({bus.ch_err_o, bus.ch_done_o, bus.sched_busy_o}),
                128'({4'b0001, 4'b0000, 1'b0}));

    $display("[TB] reset during RUN");
    launchTask(1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_outputs", 128'(allOut()), 128'(0));
    bus.dma_irq_i  = 1'b1;
    bus.dma_busy_i = 1'b0;
    step();
    rst_n = 1'b1;
    acc = pulses();
    step();
    acc |= pulses();
    bus.dma_irq_i = 1'b0;
    step();
    acc |= pulses();
    checkOutput("rst_mid_no_pulse",
                128'({acc, bus.ch_ack_o, bus.dma_start_o, bus.sched_busy_o}), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/ip_codma_task_scheduler.md
# ip_codma_task_scheduler

Multi-channel front end for the CODMA main machine. Up to NUM_CH requesters each submit a task pointer / status pointer pair; the scheduler arbitrates round-robin, launches one task at a time on the single engine through its start/pointer inputs, tracks completion, and returns per-channel done/error pulses. It also enforces a per-task watchdog and per-channel abort via the engine's stop input.

## Interface
- NUM_CH, 4, number of requesting channels, 2..8
- TMO_W, 16, width of the watchdog counter and of timeout_i
- clk_i  in  1  clock
- reset_n_i  in  1  reset; one clock, reset is asynchronous and active-low
- ch_req_i  in  NUM_CH  level request per channel; held until ch_ack_o
- ch_task_ptr_i  in  NUM_CH x 32  task pointer per channel; stable while req high
- ch_status_ptr_i  in  NUM_CH x 32  status pointer per channel; stable while req high
- ch_abort_i  in  NUM_CH  abort request; acted on only for the active channel
- ch_ack_o  out  NUM_CH  one-cycle grant pulse; pointers sampled in this cycle
- ch_done_o  out  NUM_CH  one-cycle pulse on successful completion
- ch_err_o  out  NUM_CH  one-cycle pulse on error, timeout or abort
- timeout_i  in  TMO_W  watchdog limit in cycles; 0 disables
- dma_start_o  out  1  to engine start_i
- dma_stop_o  out  1  to engine stop_i
- dma_task_ptr_o  out  32  to engine task_pointer_i
- dma_status_ptr_o  out  32  to engine status_pointer_i
- dma_busy_i  in  1  engine busy_o
- dma_irq_i  in  1  engine irq_o
- dma_err_i  in  1  engine error indication (engine state == DMA_ERROR)
- active_ch_o  out  $clog2(NUM_CH)  channel owning the engine; valid when sched_busy_o
- sched_busy_o  out  1  high in every state except SCH_IDLE

## Operation
- States: SCH_IDLE, SCH_LAUNCH, SCH_WAIT_BUSY, SCH_RUN, SCH_DRAIN.
- SCH_IDLE: if any ch_req_i and !dma_busy_i, then grant = first requesting channel at or after rr_ptr, modulo NUM_CH. Register the grant, both pointers and active channel. Go to SCH_LAUNCH.
- SCH_LAUNCH, one cycle: ch_ack_o[grant]=1 and dma_start_o=1. Set rr_ptr = (grant+1) mod NUM_CH. Go to SCH_WAIT_BUSY.
- SCH_WAIT_BUSY:
  - dma_busy_i goes to SCH_RUN.
  - 4 cycles (SCHED_BUSY_WAIT) without busy: pulse ch_err_o[active], go to SCH_IDLE.
- SCH_RUN: watchdog counts cycles from 0. Priority is highest first:
  - dma_err_i: pulse ch_err_o, go to SCH_DRAIN.
  - dma_irq_i: pulse ch_done_o, go to SCH_IDLE.
  - ch_abort_i[active] or (timeout_i!=0 and count==timeout_i-1): pulse dma_stop_o and ch_err_o, go to SCH_DRAIN.
- SCH_DRAIN: waits for !dma_busy_i, then goes to SCH_IDLE. A dma_irq_i seen here is swallowed, with no done pulse. No further err pulses are issued for this task.
- dma_task_ptr_o and dma_status_ptr_o hold the last granted values until the next grant.
- Abort on a non-active channel is ignored; that requester withdraws by dropping req.
- Exactly one ch_done_o or ch_err_o pulse per ch_ack_o.

## Timing
- All outputs are registered. Reset values: all outputs 0, rr_ptr=0, state SCH_IDLE, counter 0.
- Request in IDLE at cycle N gives ack and start at N+1. The engine asserts busy at N+2.
- Completion: dma_irq_i at cycle M gives ch_done_o at M+1. The next grant is possible from M+1, subject to !dma_busy_i.
- Watchdog: timeout_i=T gives dma_stop_o exactly T cycles after entry to SCH_RUN.
- Same-cycle events: err with irq gives err. Irq with abort or timeout gives done, and stop is not driven.
- Reset mid-task: the scheduler returns to IDLE immediately. No pulses are issued for the lost task.

## Structure
- ip_codma_pkg gains sched_state_t (enum of the five states) and the constant SCHED_BUSY_WAIT=4.
- Sub-module ip_codma_rr_arbiter: combinational rotating-priority pick. Inputs are req and rr_ptr; outputs are grant index and valid.
- The top level holds the FSM, pointer registers and watchdog.

## Test plan
- Single channel: ch1 req with task_ptr=0x100 and status_ptr=0x200.
  - Ack and start at N+1, dma_task_ptr_o=0x100.
  - Model busy, then irq 20 cycles later: one ch_done_o[1] pulse, no err.
- All four channels request together with rr_ptr=0: grant order is 0,1,2,3. A re-request by ch0 after its grant is served only after ch3.
- Watchdog: timeout_i=50 and the engine never raises irq.
  - dma_stop_o pulses 50 cycles after RUN entry, together with ch_err_o.
  - The scheduler stays in DRAIN until busy falls, swallowing the irq.
- Abort: ch2 active, ch_abort_i[2] at RUN cycle 5 gives stop plus err[2]. ch_abort_i[3] while ch2 is active has no effect.
- Collisions: dma_irq_i and abort in the same cycle give done only. dma_err_i and irq in the same cycle give err only.
- No busy response: the engine ignores start, so ch_err_o is issued 4 cycles after WAIT_BUSY entry. Also cover async reset asserted mid-RUN: all outputs 0 and no pulses.
